// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: writeback codes, EXE/MEM payload field layout
// and memory read/write encodings.
package pipe_pkg;

  localparam int WREG_W = 4;
  localparam logic [WREG_W-1:0] REG_INVALID = 4'hF;

  // EXE/MEM payload layout, LSB first: rwe | wmem_data | mem_addr | data | pc | instr
  localparam int RWE_W        = 2;
  localparam int WMEM_DATA_W  = 16;
  localparam int MEM_ADDR_W   = 16;
  localparam int DATA_W       = 16;
  localparam int PC_W         = 16;
  localparam int INSTR_W      = 16;

  localparam int RWE_OFF       = 0;
  localparam int WMEM_DATA_OFF = RWE_OFF + RWE_W;
  localparam int MEM_ADDR_OFF  = WMEM_DATA_OFF + WMEM_DATA_W;
  localparam int DATA_OFF      = MEM_ADDR_OFF + MEM_ADDR_W;
  localparam int PC_OFF        = DATA_OFF + DATA_W;
  localparam int INSTR_OFF     = PC_OFF + PC_W;

  localparam int EXE_MEM_PAYLOAD_W = INSTR_OFF + INSTR_W;

  typedef enum logic [RWE_W-1:0] {
    RWE_NONE  = 2'b00,
    RWE_READ  = 2'b01,
    RWE_WRITE = 2'b10
  } rwe_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register. An empty slot reads as a zero payload with the
// "no writeback" register code, so downstream stages see a harmless bubble.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                W           = pipe_pkg::EXE_MEM_PAYLOAD_W,
  parameter int                SLOT_WREG_W = pipe_pkg::WREG_W,
  parameter logic [SLOT_WREG_W-1:0] SLOT_REG_INVALID = pipe_pkg::REG_INVALID
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [W-1:0]           payload_i,
  input  logic [SLOT_WREG_W-1:0] wreg_i,
  output logic                   valid_o,
  output logic [W-1:0]           payload_o,
  output logic [SLOT_WREG_W-1:0] wreg_o
);

  logic                   valid_q;
  logic [W-1:0]           payload_q;
  logic [SLOT_WREG_W-1:0] wreg_q;

  // Clear wins over load so a flush can never be overridden by a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      wreg_q    <= SLOT_REG_INVALID;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      payload_q <= payload_i;
      wreg_q    <= wreg_i;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
  assign wreg_o    = wreg_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer for a pipeline stage register: full throughput with a
// fully registered upstream ready.
module pipe_skid_reg #(
  parameter int                   PAYLOAD_W   = pipe_pkg::EXE_MEM_PAYLOAD_W,
  parameter int                   WREG_W      = pipe_pkg::WREG_W,
  parameter logic [WREG_W-1:0]    REG_INVALID = pipe_pkg::REG_INVALID
) (
  input  logic                 psi_clk,
  input  logic                 psi_rst,
  input  logic                 psi_flush,
  input  logic                 psi_valid,
  output logic                 psi_ready,
  input  logic [PAYLOAD_W-1:0] psi_payload,
  input  logic [WREG_W-1:0]    psi_wreg_addr,
  output logic                 pso_valid,
  input  logic                 pso_ready,
  output logic [PAYLOAD_W-1:0] pso_payload,
  output logic [WREG_W-1:0]    pso_wreg_addr,
  output logic [1:0]           pso_count
);

  import pipe_pkg::*;

  logic                 mValid, sValid;
  logic [PAYLOAD_W-1:0] sPayload, mDin;
  logic [WREG_W-1:0]    sWreg, mWreg;
  logic                 inXfer, outXfer;
  logic                 mLoad, mClear, sLoad, sClear;
  logic                 mNext, sNext;
  logic [1:0]           count_d, count_q;

  // S is only ever occupied while M is, so !sValid is exactly "room for one more".
  assign inXfer  = psi_valid && !sValid;
  assign outXfer = mValid && pso_ready;

  assign mLoad  = !psi_flush && ((!mValid && inXfer) || (outXfer && (sValid || inXfer)));
  assign mClear = psi_flush || (outXfer && !sValid && !inXfer);
  assign sLoad  = !psi_flush && inXfer && mValid && !outXfer;
  assign sClear = psi_flush || (outXfer && sValid);

  assign mDin   = sValid ? sPayload : psi_payload;
  assign mWreg  = sValid ? sWreg : psi_wreg_addr;

  assign mNext   = !mClear && (mLoad || mValid);
  assign sNext   = !sClear && (sLoad || sValid);
  assign count_d = {1'b0, mNext} + {1'b0, sNext};

  pipe_slot #(
    .W(PAYLOAD_W), .SLOT_WREG_W(WREG_W), .SLOT_REG_INVALID(REG_INVALID)
  ) uMain (
    .clk_i(psi_clk), .rst_i(psi_rst), .clear_i(mClear), .load_i(mLoad),
    .payload_i(mDin), .wreg_i(mWreg),
    .valid_o(mValid), .payload_o(pso_payload), .wreg_o(pso_wreg_addr)
  );

  pipe_slot #(
    .W(PAYLOAD_W), .SLOT_WREG_W(WREG_W), .SLOT_REG_INVALID(REG_INVALID)
  ) uSkid (
    .clk_i(psi_clk), .rst_i(psi_rst), .clear_i(sClear), .load_i(sLoad),
    .payload_i(psi_payload), .wreg_i(psi_wreg_addr),
    .valid_o(sValid), .payload_o(sPayload), .wreg_o(sWreg)
  );

  always_ff @(posedge psi_clk) begin
    if (psi_rst) count_q <= 2'd0;
    else         count_q <= count_d;
  end

  assign psi_ready = !sValid;
  assign pso_valid = mValid;
  assign pso_count = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised and directed bench for pipe_skid_reg against a two-deep FIFO model.
module tb_pipe_skid_reg;

  localparam int PW = 82;
  localparam int WW = 4;
  localparam logic [WW-1:0] RI = 4'hF;

  logic          clk = 1'b0;
  logic          psi_rst, psi_flush, psi_valid, psi_ready, pso_valid, pso_ready;
  logic [PW-1:0] psi_payload, pso_payload;
  logic [WW-1:0] psi_wreg_addr, pso_wreg_addr;
  logic [1:0]    pso_count;

  typedef struct packed {
    logic [PW-1:0] p;
    logic [WW-1:0] w;
  } ent_t;

  ent_t modelQ[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.PAYLOAD_W(PW), .WREG_W(WW), .REG_INVALID(RI)) dut (
    .psi_clk(clk), .psi_rst(psi_rst), .psi_flush(psi_flush),
    .psi_valid(psi_valid), .psi_ready(psi_ready),
    .psi_payload(psi_payload), .psi_wreg_addr(psi_wreg_addr),
    .pso_valid(pso_valid), .pso_ready(pso_ready),
    .pso_payload(pso_payload), .pso_wreg_addr(pso_wreg_addr),
    .pso_count(pso_count)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    int n = modelQ.size();
    checkOutput("pso_valid", 128'(pso_valid), 128'(n > 0));
    checkOutput("psi_ready", 128'(psi_ready), 128'(n < 2));
    checkOutput("pso_count", 128'(pso_count), 128'(n));
    checkOutput("pso_payload", 128'(pso_payload), (n > 0) ? 128'(modelQ[0].p) : 128'(0));
    checkOutput("pso_wreg", 128'(pso_wreg_addr), (n > 0) ? 128'(modelQ[0].w) : 128'(RI));
  endtask

  // Drives one cycle of inputs, advances the model, then checks after the edge.
  task automatic applyStimulus(input logic v, input logic [PW-1:0] p, input logic [WW-1:0] w,
                               input logic rdy, input logic fl, input logic rs);
    int            n;
    bit            inX, outX, hold;
    logic [PW-1:0] heldP;
    logic [WW-1:0] heldW;
    psi_valid = v; psi_payload = p; psi_wreg_addr = w;
    pso_ready = rdy; psi_flush = fl; psi_rst = rs;
    n     = modelQ.size();
    inX   = v && (n < 2);
    outX  = (n > 0) && rdy;
    hold  = pso_valid && !rdy && !fl && !rs;
    heldP = pso_payload;
    heldW = pso_wreg_addr;
    if (rs || fl) begin
      modelQ.delete();
    end else begin
      if (outX) void'(modelQ.pop_front());
      if (inX) modelQ.push_back('{p: p, w: w});
    end
    @(posedge clk);
    @(negedge clk);
    checkAll();
    if (hold) begin
      checkOutput("stable_payload", 128'(pso_payload), 128'(heldP));
      checkOutput("stable_wreg", 128'(pso_wreg_addr), 128'(heldW));
    end
  endtask

  initial begin
    logic [95:0] r96;
    psi_rst = 1'b1; psi_flush = 1'b0; psi_valid = 1'b0; pso_ready = 1'b0;
    psi_payload = '0; psi_wreg_addr = '0;

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream at full throughput
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, PW'(i), WW'(i), 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure fills the skid slot, then drains in order
    applyStimulus(1'b1, PW'(32'h11), WW'(1), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, PW'(32'h22), WW'(2), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, PW'(32'h99), WW'(9), 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with two held and a same-cycle offer
    applyStimulus(1'b1, PW'(32'h31), WW'(3), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, PW'(32'h32), WW'(3), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, PW'(32'h33), WW'(3), 1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Reset together with flush while full, then a fresh entry
    applyStimulus(1'b1, PW'(32'h41), WW'(4), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, PW'(32'h42), WW'(4), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, PW'(32'h43), WW'(4), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, PW'(32'h44), WW'(5), 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 10000; c++) begin
      r96 = {$urandom(), $urandom(), $urandom()};
      applyStimulus(($urandom_range(0, 9) < 7), r96[PW-1:0], WW'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 255) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
